// File: rtl/prism_sp_puzzle_hw_gem_ring_acquire_mq.sv
// Multi-queue GEM descriptor prefetcher: round-robin arbitration of NQ rings onto one
// AXI read master, with 4 KiB-safe bursts, ownership stall, wrap and error handling.
module prism_sp_puzzle_hw_gem_ring_acquire_mq #(
  parameter int NQ         = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DESC_WIDTH = 64,
  parameter int VALID_BIT  = 0,
  parameter int WRAP_BIT   = 1,
  parameter int FIFO_DEPTH = 32,
  parameter int BURST_MAX  = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NQ-1:0]                       enable,
  input  logic [NQ*ADDR_WIDTH-1:0]            desc_base,
  input  logic [NQ-1:0]                       trigger,
  output logic [NQ-1:0]                       stalled,
  output logic [NQ-1:0]                       axi_err,
  output logic [NQ-1:0]                       cookie_wr_en,
  output logic [NQ*(ADDR_WIDTH+DESC_WIDTH)-1:0] cookie_wr_data,
  input  logic [NQ*CNT_W-1:0]                 cookie_wr_count,
  output logic [ADDR_WIDTH-1:0]               araddr,
  output logic [7:0]                          arlen,
  output logic [2:0]                          arsize,
  output logic [1:0]                          arburst,
  output logic [3:0]                          arcache,
  output logic                                arvalid,
  input  logic                                arready,
  input  logic [DESC_WIDTH-1:0]               rdata,
  input  logic [1:0]                          rresp,
  input  logic                                rlast,
  input  logic                                rvalid,
  output logic                                rready
);

  localparam int BYTES     = DESC_WIDTH / 8;
  localparam int BYTES_LOG = $clog2(BYTES);
  localparam int QW        = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int CW        = ADDR_WIDTH + DESC_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FIFO_DEPTH - BURST_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ADDR, S_DATA, S_SETTLE1, S_SETTLE2
  } state_e;

  state_e                  state_q, state_d;
  logic [QW-1:0]           rr_q, rr_d;
  logic [QW-1:0]           grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;

  logic [ADDR_WIDTH-1:0]   cur_q [NQ];
  logic [NQ-1:0]           stalled_q, axi_err_q, enable_q, wr_en_q;
  logic [CW-1:0]           wr_data_q;
  logic                    drop_q;

  logic [ADDR_WIDTH-1:0]   base [NQ];
  logic [NQ-1:0]           elig;
  logic                    grant_found;
  logic [QW-1:0]           grant_idx, rr_next;
  logic [12:0]             room, burst_len;
  logic                    beat, ar_hs;

  // enable_q in the eligibility term guarantees cur_q has already been loaded from base.
  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      base[q] = desc_base[q*ADDR_WIDTH +: ADDR_WIDTH];
      elig[q] = enable[q] && enable_q[q] && !stalled_q[q] &&
                (cookie_wr_count[q*CNT_W +: CNT_W] <= CNT_LIMIT);
    end
  end

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no latch can be inferred on any path.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NQ; i++) begin
      idx = (int'(rr_q) + i) % NQ;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_idx   = QW'(idx);
      end
    end
    rr_next   = QW'((int'(grant_idx) + 1) % NQ);
    room      = (13'h1000 - {1'b0, cur_q[grant_idx][11:0]}) >> BYTES_LOG;
    burst_len = (room > 13'(BURST_MAX)) ? 13'(BURST_MAX) : room;
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    case (state_q)
      S_IDLE: if (|elig) state_d = S_ARB;
      S_ARB: begin
        if (grant_found) begin
          grant_d   = grant_idx;
          rr_d      = rr_next;
          araddr_d  = cur_q[grant_idx];
          arlen_d   = 8'(burst_len - 13'd1);
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (rvalid && rlast) begin
          rready_d = 1'b0;
          state_d  = S_SETTLE1;
        end
      end
      S_SETTLE1: state_d = S_SETTLE2;
      S_SETTLE2: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked blocks use non-blocking '<=' only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign beat  = (state_q == S_DATA) && rvalid && rready_q;
  assign ar_hs = (state_q == S_ADDR) && arready;

  // Statement order sets priority: trigger, then beat (a stall beats a same-cycle
  // trigger), then the enable rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: cur_q is a small register array, not RAM, so it is reset like any flop.
      for (int q = 0; q < NQ; q++) cur_q[q] <= '0;
      stalled_q <= '0;
      axi_err_q <= '0;
      enable_q  <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      enable_q <= enable;
      wr_en_q  <= '0;
      if (ar_hs) drop_q <= 1'b0;
      for (int q = 0; q < NQ; q++) begin
        if (trigger[q] && stalled_q[q]) begin
          stalled_q[q] <= 1'b0;
          axi_err_q[q] <= 1'b0;
        end
      end
      if (beat && !drop_q) begin
        if (rresp != 2'b00) begin
          axi_err_q[grant_q] <= 1'b1;
          stalled_q[grant_q] <= 1'b1;
          drop_q             <= 1'b1;
        end else if (rdata[VALID_BIT]) begin
          stalled_q[grant_q] <= 1'b1;
          drop_q             <= 1'b1;
        end else begin
          wr_en_q[grant_q] <= 1'b1;
          wr_data_q        <= {cur_q[grant_q], rdata};
          if (rdata[WRAP_BIT]) begin
            cur_q[grant_q] <= base[grant_q];
            drop_q         <= 1'b1;
          end else begin
            cur_q[grant_q] <= cur_q[grant_q] + ADDR_WIDTH'(BYTES);
          end
        end
      end
      for (int q = 0; q < NQ; q++) begin
        if (enable[q] && !enable_q[q]) begin
          cur_q[q]     <= base[q];
          stalled_q[q] <= 1'b0;
          axi_err_q[q] <= 1'b0;
        end
      end
    end
  end

  // Only one queue writes per cycle, so a single data register fans out to every slot.
  assign cookie_wr_data = {NQ{wr_data_q}};
  assign cookie_wr_en   = wr_en_q;
  assign stalled        = stalled_q;
  assign axi_err        = axi_err_q;
  assign araddr         = araddr_q;
  assign arlen          = arlen_q;
  assign arvalid        = arvalid_q;
  assign rready         = rready_q;
  assign arsize         = 3'($clog2(DESC_WIDTH / 8));
  assign arburst        = 2'b01;
  assign arcache        = 4'b0011;

endmodule

// File: tb/tb_prism_sp_puzzle_hw_gem_ring_acquire_mq.sv
// Directed bench for the multi-queue descriptor prefetcher with a behavioural AXI read slave.
module tb_prism_sp_puzzle_hw_gem_ring_acquire_mq;
  localparam int NQ = 4, AW = 32, DW = 64, CNT_W = 6, CW = AW + DW;

  logic clock = 1'b0;
  logic reset;
  logic [NQ-1:0] enable, trigger, stalled, axi_err, cookie_wr_en;
  logic [NQ*AW-1:0] desc_base;
  logic [NQ*CW-1:0] cookie_wr_data;
  logic [NQ*CNT_W-1:0] cookie_wr_count;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [3:0] arcache;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;

  always #5 clock = ~clock;

  prism_sp_puzzle_hw_gem_ring_acquire_mq dut (
    .clock(clock), .reset(reset), .enable(enable), .desc_base(desc_base),
    .trigger(trigger), .stalled(stalled), .axi_err(axi_err),
    .cookie_wr_en(cookie_wr_en), .cookie_wr_data(cookie_wr_data),
    .cookie_wr_count(cookie_wr_count), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arcache(arcache), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; int wr_before; } ar_t;
  typedef struct { int q; logic [31:0] addr; logic [63:0] data; } wr_t;

  ar_t ar_log[$];
  wr_t wr_log[$];
  logic [63:0] mem [logic [31:0]];
  logic [31:0] err_addr = 32'hFFFF_FFF8;
  int onehot_viol = 0;
  int checks = 0, failures = 0;

  function automatic logic [63:0] mem_at(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, 32'h0};
  endfunction

  // AXI read slave plus cookie-write monitor, all sampled and driven on the falling edge.
  initial begin : slave
    logic busy, ar_hs, r_hs, ar_wait;
    logic [31:0] b_addr, a_lat, a;
    logic [7:0] l_lat;
    int beats, idx;
    ar_t ae;
    wr_t we;
    busy = 0; ar_hs = 0; r_hs = 0; ar_wait = 0; beats = 0; idx = 0;
    b_addr = 0; a_lat = 0; l_lat = 0; a = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy = 0; ar_hs = 0; r_hs = 0; ar_wait = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0;
        continue;
      end
      for (int q = 0; q < NQ; q++) begin
        if (cookie_wr_en[q]) begin
          we.q = q;
          we.addr = cookie_wr_data[q*CW+DW +: AW];
          we.data = cookie_wr_data[q*CW +: DW];
          wr_log.push_back(we);
        end
      end
      if ($countones(cookie_wr_en) > 1) onehot_viol++;
      if (ar_hs) begin
        ae.addr = a_lat; ae.len = l_lat; ae.wr_before = wr_log.size();
        ar_log.push_back(ae);
        busy = 1; b_addr = a_lat; beats = int'(l_lat) + 1; idx = 0;
      end
      if (r_hs) begin
        idx++;
        if (idx == beats) busy = 0;
      end
      arready = !busy && ar_wait && arvalid;
      ar_wait = arvalid && !busy;
      if (busy) begin
        a = b_addr + 32'(8 * idx);
        rvalid = 1; rdata = mem_at(a);
        rresp = (a == err_addr) ? 2'b10 : 2'b00;
        rlast = (idx == beats - 1);
      end else begin
        rvalid = 0; rlast = 0; rresp = 0;
      end
      ar_hs = arvalid && arready;
      r_hs = rvalid && rready;
      a_lat = araddr; l_lat = arlen;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      @(negedge clock);
      if (!arvalid && !rready) quiet++; else quiet = 0;
    end
    checks++;
    if (quiet < 4) begin failures++; $display("FAIL wait_idle got=busy exp=idle"); end
  endtask

  task automatic wait_ar(input int n);
    for (int i = 0; i < 3000 && ar_log.size() < n; i++) @(negedge clock);
    checks++;
    if (ar_log.size() < n) begin
      failures++; $display("FAIL wait_ar got=%0d exp=%0d", ar_log.size(), n);
    end
  endtask

  task automatic clear_logs();
    ar_log.delete();
    wr_log.delete();
  endtask

  task automatic test_reset();
    reset = 1; enable = '0; trigger = '0; cookie_wr_count = '0;
    desc_base = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    tick(3);
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rst_rready got=%b exp=0", rready); end
    checks++; if (stalled !== 4'h0) begin failures++; $display("FAIL rst_stalled got=%h exp=0", stalled); end
    checks++; if (axi_err !== 4'h0) begin failures++; $display("FAIL rst_axi_err got=%h exp=0", axi_err); end
    checks++; if (cookie_wr_en !== 4'h0) begin failures++; $display("FAIL rst_wr_en got=%h exp=0", cookie_wr_en); end
    checks++; if (arsize !== 3'd3) begin failures++; $display("FAIL arsize got=%0d exp=3", arsize); end
    checks++; if (arburst !== 2'b01) begin failures++; $display("FAIL arburst got=%b exp=01", arburst); end
    checks++; if (arcache !== 4'b0011) begin failures++; $display("FAIL arcache got=%b exp=0011", arcache); end
    reset = 0;
    tick(3);
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL idle_arvalid got=%b exp=0", arvalid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr [5];
    int q;
    exp_addr = '{32'h10000, 32'h20000, 32'h30000, 32'h40000, 32'h10080};
    clear_logs();
    enable = 4'hF;
    wait_ar(5);
    enable = 4'h0;
    wait_idle();
    for (int i = 0; i < 5 && i < ar_log.size(); i++) begin
      checks++; if (ar_log[i].addr !== exp_addr[i]) begin failures++; $display("FAIL rr_araddr%0d got=%h exp=%h", i, ar_log[i].addr, exp_addr[i]); end
      checks++; if (ar_log[i].len !== 8'd15) begin failures++; $display("FAIL rr_arlen%0d got=%0d exp=15", i, ar_log[i].len); end
    end
    checks++; if (wr_log.size() != 80) begin failures++; $display("FAIL rr_writes got=%0d exp=80", wr_log.size()); end
    for (int k = 0; k < 64 && k < wr_log.size(); k++) begin
      q = k / 16;
      checks++;
      if (wr_log[k].q != q || wr_log[k].addr !== 32'((q + 1) * 32'h10000 + 8 * (k % 16)) ||
          wr_log[k].data !== {wr_log[k].addr, 32'h0}) begin
        failures++;
        $display("FAIL rr_cookie%0d got=q%0d/%h exp=q%0d/%h", k, wr_log[k].q, wr_log[k].addr, q,
                 32'((q + 1) * 32'h10000 + 8 * (k % 16)));
      end
    end
  endtask

  task automatic test_4k_boundary();
    clear_logs();
    desc_base[31:0] = 32'h0000_0FC0;
    enable = 4'h1;
    wait_ar(2);
    enable = 4'h0;
    wait_idle();
    if (ar_log.size() >= 2) begin
      checks++; if (ar_log[0].addr !== 32'hFC0) begin failures++; $display("FAIL 4k_addr0 got=%h exp=fc0", ar_log[0].addr); end
      checks++; if (ar_log[0].len !== 8'd7) begin failures++; $display("FAIL 4k_len0 got=%0d exp=7", ar_log[0].len); end
      checks++; if (ar_log[1].addr !== 32'h1000) begin failures++; $display("FAIL 4k_addr1 got=%h exp=1000", ar_log[1].addr); end
      checks++; if (ar_log[1].len !== 8'd15) begin failures++; $display("FAIL 4k_len1 got=%0d exp=15", ar_log[1].len); end
      checks++; if (ar_log[1].wr_before != 8) begin failures++; $display("FAIL 4k_writes got=%0d exp=8", ar_log[1].wr_before); end
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    mem[32'h20020] = {32'h20020, 32'h2};
    enable = 4'h2;
    wait_ar(2);
    enable = 4'h0;
    wait_idle();
    if (ar_log.size() >= 2) begin
      checks++; if (ar_log[1].wr_before != 5) begin failures++; $display("FAIL wrap_writes got=%0d exp=5", ar_log[1].wr_before); end
      checks++; if (ar_log[1].addr !== 32'h20000) begin failures++; $display("FAIL wrap_next got=%h exp=20000", ar_log[1].addr); end
    end
    if (wr_log.size() >= 5) begin
      checks++; if (wr_log[4].addr !== 32'h20020 || wr_log[4].data !== {32'h20020, 32'h2}) begin
        failures++; $display("FAIL wrap_last got=%h exp=20020", wr_log[4].addr); end
    end
    checks++; if (stalled[1] !== 1'b0) begin failures++; $display("FAIL wrap_stalled got=%b exp=0", stalled[1]); end
  endtask

  task automatic test_stall();
    clear_logs();
    mem[32'h30018] = {32'h30018, 32'h1};
    enable = 4'h4;
    for (int i = 0; i < 500 && stalled[2] !== 1'b1; i++) tick(1);
    tick(50);
    checks++; if (stalled[2] !== 1'b1) begin failures++; $display("FAIL stall_set got=%b exp=1", stalled[2]); end
    checks++; if (axi_err[2] !== 1'b0) begin failures++; $display("FAIL stall_err got=%b exp=0", axi_err[2]); end
    checks++; if (wr_log.size() != 3) begin failures++; $display("FAIL stall_writes got=%0d exp=3", wr_log.size()); end
    checks++; if (ar_log.size() != 1) begin failures++; $display("FAIL stall_regrant got=%0d exp=1", ar_log.size()); end
    mem[32'h30018] = {32'h30018, 32'h0};
    trigger = 4'h4;
    tick(1);
    trigger = 4'h0;
    checks++; if (stalled[2] !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", stalled[2]); end
    wait_ar(2);
    if (ar_log.size() >= 2) begin
      checks++; if (ar_log[1].addr !== 32'h30018) begin failures++; $display("FAIL stall_resume got=%h exp=30018", ar_log[1].addr); end
    end
    enable = 4'h0;
    wait_idle();
  endtask

  task automatic test_axi_err();
    int n3;
    clear_logs();
    desc_base[31:0] = 32'h0001_0000;
    err_addr = 32'h40010;
    enable = 4'h8;
    for (int i = 0; i < 500 && axi_err[3] !== 1'b1; i++) tick(1);
    tick(5);
    checks++; if (axi_err[3] !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", axi_err[3]); end
    checks++; if (stalled[3] !== 1'b1) begin failures++; $display("FAIL err_stall got=%b exp=1", stalled[3]); end
    n3 = 0;
    foreach (wr_log[k]) if (wr_log[k].q == 3) n3++;
    checks++; if (n3 != 2) begin failures++; $display("FAIL err_writes got=%0d exp=2", n3); end
    enable = 4'h9;
    wait_ar(3);
    if (ar_log.size() >= 3) begin
      checks++; if (ar_log[1].addr !== 32'h10000) begin failures++; $display("FAIL err_other1 got=%h exp=10000", ar_log[1].addr); end
      checks++; if (ar_log[2].addr !== 32'h10080) begin failures++; $display("FAIL err_other2 got=%h exp=10080", ar_log[2].addr); end
    end
    err_addr = 32'hFFFF_FFF8;
    trigger = 4'h8;
    tick(1);
    trigger = 4'h0;
    checks++; if (stalled[3] !== 1'b0 || axi_err[3] !== 1'b0) begin
      failures++; $display("FAIL err_clear got=%b%b exp=00", stalled[3], axi_err[3]); end
    enable = 4'h0;
    wait_idle();
  endtask

  task automatic test_fifo_level();
    clear_logs();
    cookie_wr_count[0 +: CNT_W] = 6'd17;
    enable = 4'h1;
    tick(200);
    checks++; if (ar_log.size() != 0) begin failures++; $display("FAIL fifo_full got=%0d exp=0", ar_log.size()); end
    cookie_wr_count[0 +: CNT_W] = 6'd16;
    wait_ar(1);
    if (ar_log.size() >= 1) begin
      checks++; if (ar_log[0].addr !== 32'h10000) begin failures++; $display("FAIL fifo_grant got=%h exp=10000", ar_log[0].addr); end
    end
  endtask

  task automatic test_reset_mid_burst();
    mem[32'h30000] = {32'h30000, 32'h1};
    enable = 4'h5;
    for (int i = 0; i < 2000 && stalled[2] !== 1'b1; i++) tick(1);
    checks++; if (stalled[2] !== 1'b1) begin failures++; $display("FAIL rmb_stall got=%b exp=1", stalled[2]); end
    for (int i = 0; i < 2000 && rready !== 1'b1; i++) tick(1);
    #2 reset = 1;
    #1;
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin
      failures++; $display("FAIL rmb_axi got=%b%b exp=00", arvalid, rready); end
    checks++; if (stalled !== 4'h0) begin failures++; $display("FAIL rmb_stalled got=%h exp=0", stalled); end
    checks++; if (cookie_wr_en !== 4'h0) begin failures++; $display("FAIL rmb_wr_en got=%h exp=0", cookie_wr_en); end
    enable = 4'h0;
    tick(3);
    reset = 0;
    tick(5);
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rmb_after got=%b exp=0", arvalid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_4k_boundary();
    test_wrap();
    test_stall();
    test_axi_err();
    test_fifo_level();
    test_reset_mid_burst();
    checks++; if (onehot_viol != 0) begin failures++; $display("FAIL wr_onehot got=%0d exp=0", onehot_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
